// File: rtl/four_to_two_encoder.sv
// Registered 4-to-2 priority encoder (a highest, d lowest) with enable and valid flag.
// Optional `FOUR_TO_TWO_ENCODER_MULTI_EN adds a registered "multi" flag for 2+ active requests.
module four_to_two_encoder #(
  parameter bit HOLD_ON_DISABLE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic en,
`ifdef FOUR_TO_TWO_ENCODER_MULTI_EN
  output logic multi,
`endif
  output logic x,
  output logic y,
  output logic v
);

  typedef struct packed {
    logic [1:0] code;
    logic       valid;
  } enc_t;

  enc_t w_enc;
  enc_t w_next;
  enc_t r_enc;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_enc  = '0;
    w_next = r_enc;
    if (a)      w_enc = '{code: 2'b11, valid: 1'b1};
    else if (b) w_enc = '{code: 2'b10, valid: 1'b1};
    else if (c) w_enc = '{code: 2'b01, valid: 1'b1};
    else if (d) w_enc = '{code: 2'b00, valid: 1'b1};

    if (en)                   w_next = w_enc;
    else if (!HOLD_ON_DISABLE) w_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) r_enc <= '0;
    else        r_enc <= w_next;
  end

  assign x = r_enc.code[1];
  assign y = r_enc.code[0];
  assign v = r_enc.valid;

`ifdef FOUR_TO_TWO_ENCODER_MULTI_EN
  logic w_multi;
  logic w_multi_next;
  logic r_multi;

  // Any pair of requests high means two or more are active.
  always_comb begin
    w_multi      = (a & b) | (a & c) | (a & d) | (b & c) | (b & d) | (c & d);
    w_multi_next = r_multi;
    if (en)                    w_multi_next = w_multi;
    else if (!HOLD_ON_DISABLE) w_multi_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_multi <= 1'b0;
    else        r_multi <= w_multi_next;
  end

  assign multi = r_multi;
`endif

endmodule

// File: tb/tb_four_to_two_encoder.sv
// Scoreboard bench for four_to_two_encoder: one clear-on-disable and one hold-on-disable instance.
module tb_four_to_two_encoder;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c, d, en;
  logic x0, y0, v0, x1, y1, v1;
`ifdef FOUR_TO_TWO_ENCODER_MULTI_EN
  logic multi0, multi1;
`endif

  int checks   = 0;
  int failures = 0;

  // Each entry: {x0,y0,v0,mu0, x1,y1,v1,mu1}
  logic [7:0] sb[$];
  logic [3:0] m_hold;
  logic [7:0] m_last;

  always #5 clk = ~clk;

  four_to_two_encoder #(.HOLD_ON_DISABLE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .en(en),
`ifdef FOUR_TO_TWO_ENCODER_MULTI_EN
    .multi(multi0),
`endif
    .x(x0), .y(y0), .v(v0)
  );

  four_to_two_encoder #(.HOLD_ON_DISABLE(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .en(en),
`ifdef FOUR_TO_TWO_ENCODER_MULTI_EN
    .multi(multi1),
`endif
    .x(x1), .y(y1), .v(v1)
  );

  function automatic logic [7:0] get_obs();
    logic mu0 = 1'b0;
    logic mu1 = 1'b0;
`ifdef FOUR_TO_TWO_ENCODER_MULTI_EN
    mu0 = multi0;
    mu1 = multi1;
`endif
    return {x0, y0, v0, mu0, x1, y1, v1, mu1};
  endfunction

  // Reference model: {x,y,v,multi} for req = {a,b,c,d}
  function automatic logic [3:0] model(input logic [3:0] req);
    logic [3:0] r;
    logic mu = 1'b0;
`ifdef FOUR_TO_TWO_ENCODER_MULTI_EN
    mu = ($countones(req) >= 2);
`endif
    casez (req)
      4'b1???: r = {2'b11, 1'b1, mu};
      4'b01??: r = {2'b10, 1'b1, mu};
      4'b001?: r = {2'b01, 1'b1, mu};
      4'b0001: r = {2'b00, 1'b1, mu};
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Drive inputs (called just after a rising edge) and push the expected result.
  task automatic apply(input logic [3:0] req, input logic en_i);
    logic [3:0] e0, e1;
    {a, b, c, d} = req;
    en = en_i;
    e0 = en_i ? model(req) : 4'b0000;
    e1 = en_i ? model(req) : m_hold;
    m_hold = e1;
    sb.push_back({e0, e1});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs, exp;
    rst_n = 1'b0;
    {a, b, c, d} = 4'b0000;
    en = 1'b0;
    m_hold = 4'b0000;
    tick();
    tick();
    obs = get_obs();
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: got %b want %b", obs, 8'h00);
    end
    rst_n = 1'b1;
    apply(4'b1000, 1'b1);
    tick();
    exp = sb.pop_front();
    obs = get_obs();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_release_first_edge: got %b want %b", obs, exp);
    end
    // Assert reset mid-cycle with a=1, en=1: outputs must clear without a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    obs = get_obs();
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL reset_async_clear: got %b want %b", obs, 8'h00);
    end
    @(posedge clk);
    #1;
    obs = get_obs();
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL reset_held_over_edge: got %b want %b", obs, 8'h00);
    end
    rst_n  = 1'b1;
    m_hold = 4'b0000;
    m_last = 8'h00;
  endtask

  task automatic test_onehot_sweep();
    logic [7:0] obs, exp;
    logic [3:0] pats [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      apply(pats[i], 1'b1);
      tick();
      exp = sb.pop_front();
      obs = get_obs();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL onehot_%b: got %b want %b", pats[i], obs, exp);
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] obs, exp;
    logic [3:0] pats [4] = '{4'b0111, 4'b1111, 4'b1010, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      apply(pats[i], 1'b1);
      tick();
      exp = sb.pop_front();
      obs = get_obs();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL priority_%b: got %b want %b", pats[i], obs, exp);
      end
    end
  endtask

  task automatic test_idle();
    logic [7:0] obs, exp;
    logic [3:0] pats [2] = '{4'b0001, 4'b0000};
    for (int i = 0; i < 2; i++) begin
      apply(pats[i], 1'b1);
      tick();
      exp = sb.pop_front();
      obs = get_obs();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL idle_vs_d_%b: got %b want %b", pats[i], obs, exp);
      end
    end
  endtask

  task automatic test_disable();
    logic [7:0] obs, exp;
    logic [3:0] reqs [5] = '{4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b1100};
    logic       ens  [5] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(reqs[i], ens[i]);
      tick();
      exp = sb.pop_front();
      obs = get_obs();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL disable_step%0d_en%b_req%b: got %b want %b", i, ens[i], reqs[i], obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] obs, exp;
    logic [3:0] req;
    apply(4'b0000, 1'b1);
    tick();
    m_last = sb.pop_front();
    for (int i = 0; i < 8; i++) begin
      req = 4'b0001 << (($urandom_range(0, 3) + i) % 4);
      apply(req, 1'b1);
      // Before the edge the outputs must still show the previous sample.
      #2;
      obs = get_obs();
      checks++;
      if (obs !== m_last) begin
        failures++;
        $display("FAIL b2b_pre_edge_%0d: got %b want %b", i, obs, m_last);
      end
      tick();
      exp = sb.pop_front();
      obs = get_obs();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL b2b_cycle_%0d_req%b: got %b want %b", i, req, obs, exp);
      end
      m_last = exp;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_onehot_sweep();
    test_priority();
    test_idle();
    test_disable();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
